// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the pipeline sequencer: opcodes, sequencer states,
// trap causes and the control word the sequencer drives into the pipeline.
package cpu_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_LBU  = 4'b1010;
  localparam logic [3:0] OP_SB   = 4'b1011;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_ALU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'b00,
    EXC_OVF    = 2'b01,
    EXC_MEM_TO = 2'b10
  } exc_cause_e;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_exc;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
    logic halted;
    logic exc_valid;
  } seq_ctrl_t;

  // Normal flow: everything advances, nothing flushed.
  localparam seq_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, pc_sel_exc: 1'b0,
    if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_flush: 1'b0, id_flush: 1'b0, ex_flush: 1'b0,
    halted: 1'b0, exc_valid: 1'b0
  };

  localparam seq_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, pc_sel_exc: 1'b0,
    if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_flush: 1'b0, id_flush: 1'b0, ex_flush: 1'b0,
    halted: 1'b0, exc_valid: 1'b0
  };

  // Vector to the handler and squash everything younger than MEM.
  localparam seq_ctrl_t CTRL_TRAP = '{
    pc_en: 1'b1, pc_sel_exc: 1'b1,
    if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_flush: 1'b1, id_flush: 1'b1, ex_flush: 1'b1,
    halted: 1'b0, exc_valid: 1'b1
  };

  localparam seq_ctrl_t CTRL_HALT = '{
    pc_en: 1'b0, pc_sel_exc: 1'b0,
    if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_flush: 1'b0, id_flush: 1'b0, ex_flush: 1'b0,
    halted: 1'b1, exc_valid: 1'b0
  };

  // Held while reset is low so the pipeline fills with NOPs.
  localparam seq_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, pc_sel_exc: 1'b0,
    if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_flush: 1'b1, id_flush: 1'b1, ex_flush: 1'b1,
    halted: 1'b0, exc_valid: 1'b0
  };

  function automatic logic uses_rt(input logic [3:0] op);
    case (op)
      OP_ALU, OP_SB, OP_SW, OP_BGT, OP_BLT, OP_BEQ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LBU) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Status/control bundle between the pipeline datapath (master) and the
// sequencer (slave).
interface pipeline_sequencer_if;
  logic [3:0] id_opcode;
  logic       id_valid;
  logic [3:0] id_rs_addr;
  logic [3:0] id_rt_addr;
  logic       id_branch_taken;
  logic [3:0] ex_opcode;
  logic       ex_valid;
  logic [3:0] ex_rd_addr;
  logic       ex_overflow;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_en;
  logic       pc_sel_exc;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_flush;
  logic       id_flush;
  logic       ex_flush;
  logic       halted;
  logic       exc_valid;
  logic [1:0] exc_cause;

  modport master (
    output id_opcode, id_valid, id_rs_addr, id_rt_addr, id_branch_taken,
           ex_opcode, ex_valid, ex_rd_addr, ex_overflow, mem_req, mem_ready,
    input  pc_en, pc_sel_exc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_flush, id_flush, ex_flush, halted, exc_valid, exc_cause
  );

  modport slave (
    input  id_opcode, id_valid, id_rs_addr, id_rt_addr, id_branch_taken,
           ex_opcode, ex_valid, ex_rd_addr, ex_overflow, mem_req, mem_ready,
    output pc_en, pc_sel_exc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_flush, id_flush, ex_flush, halted, exc_valid, exc_cause
  );
endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [3:0] ex_rd_addr,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs_addr,
  input  logic [3:0] id_rt_addr,
  output logic       lu_stall
);
  logic rs_hit, rt_hit;

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign rs_hit   = (ex_rd_addr == id_rs_addr);
  assign rt_hit   = uses_rt(id_opcode) && (ex_rd_addr == id_rt_addr);
  assign lu_stall = ex_valid && is_load(ex_opcode) && (ex_rd_addr != 4'd0)
                    && (rs_hit || rt_hit);
endmodule

// File: rtl/pipeline_sequencer.sv
// Central 5-stage pipeline sequencer: memory stalls, traps, load-use bubbles,
// halt drain and redirects, resolved in that priority order.
module pipeline_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_sequencer_if.slave  seq
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  seq_state_e     state, state_nxt;
  exc_cause_e     cause, cause_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [DCW-1:0] drain_cnt, drain_nxt;
  seq_ctrl_t      ctl;

  logic lu_stall, mem_stall, ovf, halt_id, redirect;

  hazard_detect u_hazard (
    .ex_valid   (seq.ex_valid),
    .ex_opcode  (seq.ex_opcode),
    .ex_rd_addr (seq.ex_rd_addr),
    .id_opcode  (seq.id_opcode),
    .id_rs_addr (seq.id_rs_addr),
    .id_rt_addr (seq.id_rt_addr),
    .lu_stall   (lu_stall)
  );

  assign mem_stall = seq.mem_req && !seq.mem_ready;
  assign ovf       = seq.ex_valid && seq.ex_overflow;
  assign halt_id   = seq.id_valid && (seq.id_opcode == OP_HALT);
  assign redirect  = seq.id_valid && ((seq.id_opcode == OP_JMP) || seq.id_branch_taken);

  always_comb begin
    ctl       = CTRL_RUN;
    state_nxt = state;
    cause_nxt = cause;
    wait_nxt  = wait_cnt;
    drain_nxt = drain_cnt;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          ctl       = CTRL_FREEZE;
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = WCW'(1);
        end else if (ovf) begin
          ctl       = CTRL_TRAP;
          cause_nxt = EXC_OVF;
        end else if (lu_stall) begin
          // Hold IF/ID and the PC, let EX move on with a bubble behind it.
          ctl.pc_en    = 1'b0;
          ctl.if_id_en = 1'b0;
          ctl.id_flush = 1'b1;
        end else if (halt_id) begin
          ctl.pc_en    = 1'b0;
          ctl.if_flush = 1'b1;
          state_nxt    = ST_DRAIN;
          drain_nxt    = '0;
        end else if (redirect) begin
          ctl.if_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (seq.mem_ready) begin
          state_nxt = ST_RUN;
          if (ovf) begin
            ctl       = CTRL_TRAP;
            cause_nxt = EXC_OVF;
          end
        end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
          // Abandon the access: the stuck MEM op is retired as a trap.
          ctl       = CTRL_TRAP;
          cause_nxt = EXC_MEM_TO;
          state_nxt = ST_RUN;
        end else begin
          ctl      = CTRL_FREEZE;
          wait_nxt = wait_cnt + WCW'(1);
        end
      end
      ST_DRAIN: begin
        if (mem_stall) begin
          ctl = CTRL_FREEZE;
        end else if (ovf) begin
          ctl       = CTRL_TRAP;
          cause_nxt = EXC_OVF;
          state_nxt = ST_RUN;
        end else begin
          ctl.pc_en    = 1'b0;
          ctl.if_flush = 1'b1;
          if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) state_nxt = ST_HALTED;
          else                                      drain_nxt = drain_cnt + DCW'(1);
        end
      end
      ST_HALTED: ctl = CTRL_HALT;
      default:   ctl = CTRL_RUN;
    endcase
    if (!reset) ctl = CTRL_RESET;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      cause     <= EXC_NONE;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cause     <= cause_nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  assign seq.pc_en      = ctl.pc_en;
  assign seq.pc_sel_exc = ctl.pc_sel_exc;
  assign seq.if_id_en   = ctl.if_id_en;
  assign seq.id_ex_en   = ctl.id_ex_en;
  assign seq.ex_mem_en  = ctl.ex_mem_en;
  assign seq.mem_wb_en  = ctl.mem_wb_en;
  assign seq.if_flush   = ctl.if_flush;
  assign seq.id_flush   = ctl.id_flush;
  assign seq.ex_flush   = ctl.ex_flush;
  assign seq.halted     = ctl.halted;
  assign seq.exc_valid  = ctl.exc_valid;
  assign seq.exc_cause  = cause;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed scenarios then random traffic.
module tb_pipeline_sequencer;
  localparam int MEM_TIMEOUT  = 15;
  localparam int DRAIN_CYCLES = 3;

  localparam logic [3:0] HALT = 4'b0000, ANDI = 4'b0001, BEQ = 4'b0110, JMP = 4'b0111;
  localparam logic [3:0] LBU  = 4'b1010, LW = 4'b1100, ALU = 4'b1111;

  typedef struct packed {
    logic [3:0] id_opcode; logic id_valid; logic [3:0] rs; logic [3:0] rt; logic br;
    logic [3:0] ex_opcode; logic ex_valid; logic [3:0] rd; logic ovf;
    logic mem_req; logic mem_ready; logic rst_n;
  } stim_t;

  // pc_en, pc_sel_exc, en[if_id,id_ex,ex_mem,mem_wb], fl[if,id,ex], halted, exc_valid, cause
  typedef struct packed {
    logic pc; logic sel; logic [3:0] en; logic [2:0] fl; logic h; logic xv; logic [1:0] cause;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_sequencer_if bus();
  pipeline_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .reset(rst_n), .seq(bus)
  );

  exp_t  sb[$];
  string tq[$];
  int    vectors = 0, miscomp = 0;

  // Reference state: 0 run, 1 waiting on memory, 2 draining, 3 halted.
  int m_mode = 0, m_wait = 0, m_drain = 0, m_cause = 0;
  int n_mode, n_wait, n_drain, n_cause;

  function automatic exp_t outs(bit pc, bit sel, bit [3:0] en, bit [2:0] fl, bit h, bit xv);
    exp_t e;
    e.pc = pc; e.sel = sel; e.en = en; e.fl = fl; e.h = h; e.xv = xv;
    e.cause = m_cause[1:0];
    return e;
  endfunction

  function automatic bit reads_rt(logic [3:0] op);
    return op inside {4'b1111, 4'b1011, 4'b1101, 4'b0100, 4'b0101, 4'b0110};
  endfunction

  function automatic exp_t model(stim_t s);
    exp_t dflt, trap, frz, e;
    bit stall, ovf, lu, halt, redir;
    dflt  = outs(1, 0, 4'b1111, 3'b000, 0, 0);
    trap  = outs(1, 1, 4'b1111, 3'b111, 0, 1);
    frz   = outs(0, 0, 4'b0000, 3'b000, 0, 0);
    stall = s.mem_req && !s.mem_ready;
    ovf   = s.ex_valid && s.ovf;
    lu    = s.ex_valid && (s.ex_opcode == LW || s.ex_opcode == LBU) && s.rd != 0 &&
            (s.rd == s.rs || (reads_rt(s.id_opcode) && s.rd == s.rt));
    halt  = s.id_valid && s.id_opcode == HALT;
    redir = s.id_valid && (s.id_opcode == JMP || s.br);
    n_mode = m_mode; n_wait = m_wait; n_drain = m_drain; n_cause = m_cause;
    e = dflt;
    case (m_mode)
      0: if (stall) begin e = frz; n_mode = 1; n_wait = 1; end
         else if (ovf) begin e = trap; n_cause = 1; end
         else if (lu) e = outs(0, 0, 4'b0111, 3'b010, 0, 0);
         else if (halt) begin e = outs(0, 0, 4'b1111, 3'b100, 0, 0); n_mode = 2; n_drain = 0; end
         else if (redir) e = outs(1, 0, 4'b1111, 3'b100, 0, 0);
      1: if (s.mem_ready) begin
           n_mode = 0;
           if (ovf) begin e = trap; n_cause = 1; end
         end else if (m_wait == MEM_TIMEOUT) begin e = trap; n_cause = 2; n_mode = 0; end
         else begin e = frz; n_wait = m_wait + 1; end
      2: if (stall) e = frz;
         else if (ovf) begin e = trap; n_cause = 1; n_mode = 0; end
         else begin
           e = outs(0, 0, 4'b1111, 3'b100, 0, 0);
           if (m_drain == DRAIN_CYCLES - 1) n_mode = 3; else n_drain = m_drain + 1;
         end
      default: e = outs(0, 0, 4'b0000, 3'b000, 1, 0);
    endcase
    if (!s.rst_n) begin
      e = outs(0, 0, 4'b1111, 3'b111, 0, 0);
      n_mode = 0; n_wait = 0; n_drain = 0; n_cause = 0;
    end
    return e;
  endfunction

  task automatic drive(stim_t s);
    bus.id_opcode = s.id_opcode; bus.id_valid = s.id_valid;
    bus.id_rs_addr = s.rs; bus.id_rt_addr = s.rt; bus.id_branch_taken = s.br;
    bus.ex_opcode = s.ex_opcode; bus.ex_valid = s.ex_valid;
    bus.ex_rd_addr = s.rd; bus.ex_overflow = s.ovf;
    bus.mem_req = s.mem_req; bus.mem_ready = s.mem_ready;
    rst_n = s.rst_n;
  endtask

  task automatic cyc(stim_t s, string tag);
    exp_t e;
    drive(s);
    e = model(s);
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    m_mode = n_mode; m_wait = n_wait; m_drain = n_drain; m_cause = n_cause;
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    s.mem_ready = 1'b1;
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a control word; compare mid-cycle.
  always @(negedge clk) begin
    exp_t  e, a;
    string t;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      a = {bus.pc_en, bus.pc_sel_exc, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
           bus.mem_wb_en, bus.if_flush, bus.id_flush, bus.ex_flush, bus.halted,
           bus.exc_valid, bus.exc_cause};
      vectors++;
      if (a !== e) begin
        miscomp++;
        $display("FAIL %s @%0t: got %b required %b (pc sel en4 fl3 h xv cause)", t, $time, a, e);
      end
    end
  end

  initial begin
    stim_t s;
    int halted_for;
    s = idle(); s.rst_n = 1'b0;
    drive(s);
    @(posedge clk); #1;

    repeat (2) cyc(s, "reset");
    s = idle();
    repeat (2) cyc(s, "run_default");

    // Load-use via rs, then the bubble cycle returns to default.
    s = idle(); s.ex_valid = 1; s.ex_opcode = LW; s.rd = 3;
    s.id_valid = 1; s.id_opcode = ALU; s.rs = 3; s.rt = 5;
    cyc(s, "lu_rs");
    s.ex_valid = 0; cyc(s, "lu_after");
    s = idle(); s.ex_valid = 1; s.ex_opcode = LBU; s.rd = 3;
    s.id_valid = 1; s.id_opcode = ALU; s.rs = 4; s.rt = 3;
    cyc(s, "lu_rt");
    s.id_opcode = ANDI; cyc(s, "lu_rt_unused");
    s.id_opcode = ALU; s.rd = 0; s.rs = 0; s.rt = 0; cyc(s, "lu_r0");

    // Four-cycle memory wait, released by mem_ready.
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (4) cyc(s, "mem_wait");
    s.mem_ready = 1; cyc(s, "mem_release");
    s = idle(); cyc(s, "after_release");

    // Timeout: stall cycle plus 15 waiting cycles, trap on the last.
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (1 + MEM_TIMEOUT) cyc(s, "mem_timeout");
    s = idle(); repeat (2) cyc(s, "post_timeout");

    // Overflow beats a taken branch in ID.
    s = idle(); s.id_valid = 1; s.id_opcode = BEQ; s.br = 1;
    s.ex_valid = 1; s.ex_opcode = ALU; s.ovf = 1;
    cyc(s, "ovf_vs_beq");
    s.ovf = 0; s.ex_valid = 0; cyc(s, "beq_redirect");
    s = idle(); s.id_valid = 1; s.id_opcode = JMP; cyc(s, "jmp_redirect");

    // Halt: three drain cycles then parked until reset.
    s = idle(); s.id_valid = 1; s.id_opcode = HALT; cyc(s, "halt_id");
    s = idle(); repeat (DRAIN_CYCLES) cyc(s, "drain");
    repeat (20) begin
      s.mem_req = 1'($urandom); s.mem_ready = 1'($urandom);
      s.ex_valid = 1'($urandom); s.ovf = 1'($urandom);
      cyc(s, "halted");
    end
    s = idle(); s.rst_n = 0; cyc(s, "halt_reset");

    // Reset in MEM_WAIT after an overflow set the sticky cause.
    s = idle(); s.ex_valid = 1; s.ovf = 1; cyc(s, "ovf_set");
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (3) cyc(s, "wait_pre_reset");
    s.rst_n = 0; cyc(s, "reset_in_wait");
    s = idle(); repeat (2) cyc(s, "after_wait_reset");

    halted_for = 0;
    repeat (3000) begin
      s.rst_n     = ($urandom_range(199) != 0) && (halted_for < 6);
      s.id_opcode = 4'($urandom);
      s.id_valid  = ($urandom_range(3) != 0);
      s.rs        = 4'($urandom_range(3));
      s.rt        = 4'($urandom_range(3));
      s.br        = ($urandom_range(5) == 0);
      s.ex_opcode = $urandom_range(1) ? (1'($urandom) ? LW : LBU) : 4'($urandom);
      s.ex_valid  = ($urandom_range(3) != 0);
      s.rd        = 4'($urandom_range(3));
      s.ovf       = ($urandom_range(15) == 0);
      s.mem_req   = ($urandom_range(3) == 0);
      s.mem_ready = ($urandom_range(2) != 0);
      cyc(s, "random");
      halted_for = (m_mode == 3) ? halted_for + 1 : 0;
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscomp++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end
endmodule
